// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared next-PC op encodings, redirect FSM states and PC defaults
package pc_redirect_unit_pkg;
  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JALR   = 3'b100
  } npcop_e;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_e;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: redirect target selection and misalignment detection
module pc_target_calc
  import pc_redirect_unit_pkg::*;
(
  input  logic [2:0]  npcop,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] aluout,
  output logic [31:0] target,
  output logic        misaligned
);
  assign target = npcop == NPC_JALR ? {aluout[31:1], 1'b0} : pc + imm;
  // any low bit set would leave the fetch PC off a word boundary
  assign misaligned = |target[1:0];
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with branch/jump redirect, stall hold and misalignment trap
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        mem_valid,
  input  logic [2:0]  mem_npcop,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_imm,
  input  logic [31:0] mem_aluout,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign,
  output logic [31:0] misalign_pc,
  output logic [15:0] redir_cnt
);
  state_e      state, state_nx;
  logic [31:0] target, pc_nx;
  logic        mis_t, redir, fault;
  pc_target_calc u_calc (
    .npcop     (mem_npcop),
    .pc        (mem_pc),
    .imm       (mem_imm),
    .aluout    (mem_aluout),
    .target    (target),
    .misaligned(mis_t)
  );
  assign redir       = mem_valid && mem_npcop != NPC_PLUS4 && state != BOOT;
  assign fault       = redir && mis_t;
  assign flush       = redir;
  assign fetch_valid = state != BOOT;
  assign misalign    = state == TRAP;
  always_comb begin
    state_nx = fault ? TRAP : (state == TRAP && trap_ack) ? RUN : state;
    pc_nx    = pc + 32'd4;
    if (state == BOOT) begin
      state_nx = RUN;
      pc_nx    = pc;
    end else if (redir) pc_nx = fault ? TRAP_VEC : target;
    else if (stall) pc_nx = pc;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      misalign_pc <= '0;
      redir_cnt   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (fault && !misalign) misalign_pc <= mem_pc;
      if (redir && redir_cnt != 16'hFFFF) redir_cnt <= redir_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and randomized checks of pc_redirect_unit against a behavioural model
module tb_pc_redirect_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;
  logic        clk = 0, rstn = 1, stall = 0, mem_valid = 0, trap_ack = 0;
  logic [2:0]  mem_npcop = 0;
  logic [31:0] mem_pc = 0, mem_imm = 0, mem_aluout = 0;
  logic [31:0] pc, misalign_pc;
  logic        fetch_valid, flush, misalign;
  logic [15:0] redir_cnt;
  int total = 0, bad = 0;
  logic [31:0] m_pc, m_mpc;
  int          m_cnt;
  bit          m_boot, m_trap;
  pc_redirect_unit dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .mem_valid  (mem_valid),
    .mem_npcop  (mem_npcop),
    .mem_pc     (mem_pc),
    .mem_imm    (mem_imm),
    .mem_aluout (mem_aluout),
    .trap_ack   (trap_ack),
    .pc         (pc),
    .fetch_valid(fetch_valid),
    .flush      (flush),
    .misalign   (misalign),
    .misalign_pc(misalign_pc),
    .redir_cnt  (redir_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One clock: compare outputs to the model mid-cycle, then advance the model across the edge
  task automatic cycle(input bit chk);
    bit req, f, st, ack;
    logic [31:0] tgt, mpc;
    #1;
    req = !m_boot && mem_valid && mem_npcop != 3'b000;
    tgt = mem_npcop == 3'b100 ? mem_aluout - (mem_aluout % 2) : mem_pc + mem_imm;
    f   = req && (tgt % 4 != 0);
    st  = stall;
    ack = trap_ack;
    mpc = mem_pc;
    if (chk) begin
      check("pc", pc, m_pc);
      check("fetch_valid", {31'b0, fetch_valid}, {31'b0, !m_boot});
      check("flush", {31'b0, flush}, {31'b0, req});
      check("misalign", {31'b0, misalign}, {31'b0, m_trap});
      check("misalign_pc", misalign_pc, m_mpc);
      check("redir_cnt", {16'b0, redir_cnt}, m_cnt);
    end
    @(posedge clk);
    if (m_boot) m_boot = 0;
    else begin
      if (req && m_cnt < 65535) m_cnt++;
      if (f) begin
        if (!m_trap) m_mpc = mpc;
        m_trap = 1;
        m_pc = TVEC;
      end else begin
        if (req) m_pc = tgt;
        else if (!st) m_pc = m_pc + 4;
        if (m_trap && ack) m_trap = 0;
      end
    end
    #1;
  endtask
  task automatic reset_mid();
    #2;
    rstn = 0;
    mem_valid = 1;
    mem_npcop = 3'b010;
    #1;
    m_pc = RST_PC; m_boot = 1; m_trap = 0; m_cnt = 0; m_mpc = 0;
    check("rst_pc", pc, RST_PC);
    check("rst_fetch_valid", {31'b0, fetch_valid}, 0);
    check("rst_misalign", {31'b0, misalign}, 0);
    check("rst_misalign_pc", misalign_pc, 0);
    check("rst_redir_cnt", {16'b0, redir_cnt}, 0);
    check("rst_flush", {31'b0, flush}, 0);
    #1;
    rstn = 1;
    mem_valid = 0;
    mem_npcop = 0;
  endtask
  initial begin
    logic [2:0] ops [4];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100;
    @(posedge clk);
    #1;
    reset_mid();
    cycle(1);
    check("run_pc0", pc, 32'h0);
    check("run_fv", {31'b0, fetch_valid}, 1);
    cycle(1);
    check("run_pc4", pc, 32'h4);
    cycle(1);
    check("run_pc8", pc, 32'h8);
    mem_valid = 1; mem_npcop = 3'b001; mem_pc = 32'h20; mem_imm = 32'hFFFF_FFF0;
    #1;
    check("br_flush", {31'b0, flush}, 1);
    cycle(1);
    check("br_pc", pc, 32'h10);
    check("br_cnt", {16'b0, redir_cnt}, 1);
    stall = 1; mem_npcop = 3'b100; mem_aluout = 32'h0000_0105;
    cycle(1);
    check("jalr_pc", pc, 32'h104);
    stall = 0; mem_npcop = 3'b010; mem_pc = 32'h40; mem_imm = 32'h6;
    cycle(1);
    check("mis_pc", pc, TVEC);
    check("mis_flag", {31'b0, misalign}, 1);
    check("mis_mpc", misalign_pc, 32'h40);
    mem_pc = 32'h80;
    cycle(1);
    check("mis2_mpc", misalign_pc, 32'h40);
    trap_ack = 1;
    cycle(1);
    check("ack_fault_wins", {31'b0, misalign}, 1);
    mem_valid = 0;
    cycle(1);
    check("ack_clear", {31'b0, misalign}, 0);
    trap_ack = 0; mem_valid = 1; mem_pc = 32'hFFFF_FFFC; mem_imm = 32'h8;
    cycle(1);
    check("wrap_pc", pc, 32'h4);
    mem_valid = 0; stall = 1;
    cycle(1);
    check("stall_hold", pc, 32'h4);
    stall = 0;
    repeat (400) begin
      mem_valid  = $urandom_range(0, 1) == 1;
      mem_npcop  = ops[$urandom_range(0, 3)];
      mem_pc     = $urandom & 32'hFFFF_FFFC;
      mem_imm    = $urandom_range(0, 1) == 1 ? ($urandom & 32'hFFFF_FFFE) : 32'($urandom_range(0, 64)) * 2;
      mem_aluout = $urandom;
      stall      = $urandom_range(0, 3) == 0;
      trap_ack   = $urandom_range(0, 3) == 0;
      cycle(1);
    end
    stall = 0; trap_ack = 0; mem_valid = 1; mem_npcop = 3'b010; mem_pc = 32'h40; mem_imm = 32'h6;
    cycle(1);
    check("pre_rst_trap", {31'b0, misalign}, 1);
    reset_mid();
    mem_valid = 1; mem_npcop = 3'b010; mem_pc = 32'h0; mem_imm = 32'h0;
    cycle(1);
    repeat (65535) cycle(0);
    check("sat_reach", {16'b0, redir_cnt}, 32'hFFFF);
    cycle(1);
    check("sat_hold", {16'b0, redir_cnt}, 32'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
